// File: rtl/sw_hw_pio_rx_if.sv
// Signal bundle between the PIO receiver and its neighbours: the software PIO
// handshake pins, the outgoing word stream, and status/debug observables.
interface sw_hw_pio_rx_if #(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = 16
);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic [DATA_W-1:0] to_hw_port;
  logic [1:0]        to_hw_sig;
  logic [1:0]        to_sw_sig;
  // Stream handshake: a word moves on a rising edge where out_valid and
  // out_ready are both high; out_data is stable while out_valid waits.
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic [LVL_W-1:0]  fifo_level;
  logic [CNT_W-1:0]  word_count;
  logic [CNT_W-1:0]  last_count;
  logic              xfer_done;
  logic              proto_err;
  logic              fsm_state;

  modport slave (
    input  to_hw_port, to_hw_sig, out_ready,
    output to_sw_sig, out_data, out_valid, fifo_level, word_count,
           last_count, xfer_done, proto_err, fsm_state
  );

  modport master (
    output to_hw_port, to_hw_sig, out_ready,
    input  to_sw_sig, out_data, out_valid, fifo_level, word_count,
           last_count, xfer_done, proto_err, fsm_state
  );
endinterface

// File: rtl/sw_hw_pio_rx.sv
// Hardware end of the software-to-hardware PIO channel: four-phase handshake
// with software, FIFO buffering, and a show-ahead valid/ready word stream.
module sw_hw_pio_rx #(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = 16
) (
  input  logic             clk_50,
  input  logic             reset_reset_n,
  sw_hw_pio_rx_if.slave    bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  typedef enum logic {IDLE = 1'b0, ACK = 1'b1} state_e;

  state_e            state_q;
  logic [1:0]        sig_q;
  logic [1:0]        ack_code_q;
  logic [DATA_W-1:0] port_q;
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [LVL_W-1:0]  level_q;
  logic [LVL_W-1:0]  level_d;
  logic              full_q;
  logic              valid_q;
  logic              ack_q;
  logic              xfer_done_q;
  logic              proto_err_q;
  logic [CNT_W-1:0]  word_count_q;
  logic [CNT_W-1:0]  last_count_q;

  logic full;
  logic rd_en;
  logic wr_en;
  logic end_en;
  logic abort_en;

  // Write eligibility looks at the pre-read level, so a full FIFO never
  // accepts a word in the same cycle that a word leaves.
  assign full     = (level_q == LVL_W'(FIFO_DEPTH));
  assign rd_en    = valid_q & bus.out_ready;
  assign wr_en    = (state_q == IDLE) && (sig_q == 2'b01) && !full;
  assign end_en   = (state_q == IDLE) && (sig_q == 2'b10) && (level_q == '0);
  assign abort_en = (state_q == IDLE) && (sig_q == 2'b11);

  always_comb begin
    level_d = level_q;
    if (abort_en) level_d = '0;
    else          level_d = level_q + LVL_W'(wr_en) - LVL_W'(rd_en);
  end

  always_ff @(posedge clk_50) begin
    if (!reset_reset_n) begin
      state_q      <= IDLE;
      sig_q        <= 2'b00;
      ack_code_q   <= 2'b00;
      port_q       <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      full_q       <= 1'b0;
      valid_q      <= 1'b0;
      ack_q        <= 1'b0;
      xfer_done_q  <= 1'b0;
      proto_err_q  <= 1'b0;
      word_count_q <= '0;
      last_count_q <= '0;
    end else begin
      sig_q       <= bus.to_hw_sig;
      port_q      <= bus.to_hw_port;
      level_q     <= level_d;
      valid_q     <= (level_d != '0);
      full_q      <= (level_d == LVL_W'(FIFO_DEPTH));
      xfer_done_q <= 1'b0;
      // A read in the abort cycle still completes; the flush then zeroes both pointers.
      if (abort_en) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(wr_en);
        rd_ptr_q <= rd_ptr_q + PTR_W'(rd_en);
      end
      case (state_q)
        IDLE: begin
          if (wr_en) begin
            word_count_q <= word_count_q + 1'b1;
            ack_code_q   <= 2'b01;
            state_q      <= ACK;
            ack_q        <= 1'b1;
          end else if (end_en) begin
            last_count_q <= word_count_q;
            word_count_q <= '0;
            xfer_done_q  <= 1'b1;
            ack_code_q   <= 2'b10;
            state_q      <= ACK;
            ack_q        <= 1'b1;
          end else if (abort_en) begin
            word_count_q <= '0;
            ack_code_q   <= 2'b11;
            state_q      <= ACK;
            ack_q        <= 1'b1;
          end
        end
        ACK: begin
          if (sig_q == 2'b00) begin
            state_q <= IDLE;
            ack_q   <= 1'b0;
          end else if (sig_q != ack_code_q) begin
            proto_err_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Storage carries no reset; contents are meaningless until written.
  always_ff @(posedge clk_50) begin
    if (reset_reset_n && wr_en) mem_q[wr_ptr_q] <= port_q;
  end

  assign bus.to_sw_sig  = {full_q, ack_q};
  assign bus.out_data   = mem_q[rd_ptr_q];
  assign bus.out_valid  = valid_q;
  assign bus.fifo_level = level_q;
  assign bus.word_count = word_count_q;
  assign bus.last_count = last_count_q;
  assign bus.xfer_done  = xfer_done_q;
  assign bus.proto_err  = proto_err_q;
  assign bus.fsm_state  = state_q;
endmodule

// File: doc/sw_hw_pio_rx.md
# sw_hw_pio_rx

Hardware-side receiver for the 16-bit software-to-hardware PIO channel in the SD-card NIOS system. Software writes a word to `to_hw_port`, signals with `to_hw_sig`, and waits for acknowledge on `to_sw_sig`. This block is the other end of that channel. It performs the four-phase handshake, buffers received words in a FIFO, and presents them as a valid/ready stream to fabric consumers. It also handles end-of-transfer and abort commands.

## Interface
- `DATA_W`, 16: word width; must match `to_hw_port`.
- `FIFO_DEPTH`, 16: FIFO entries; power of two, ≥2.
- `CNT_W`, 16: width of the word counters.
- `clk_50`  in  1: system clock; all logic is on the rising edge.
- `reset_reset_n`  in  1: synchronous, active-low reset. One clock; reset is synchronous and active-low.
- `to_hw_port`  in  DATA_W: data word from software.
- `to_hw_sig`  in  2: command. 00 = idle, 01 = data valid, 10 = end of transfer, 11 = abort.
- `to_sw_sig`  out  2: bit0 = ack, bit1 = busy (FIFO full).
- `out_data`  out  DATA_W: FIFO head word (show-ahead).
- `out_valid`  out  1: FIFO not empty.
- `out_ready`  in  1: consumer accepts `out_data` when `out_valid & out_ready`.
- `fifo_level`  out  log2(FIFO_DEPTH)+1: current occupancy.
- `word_count`  out  CNT_W: words accepted in the current transfer.
- `last_count`  out  CNT_W: `word_count` latched at the last end-of-transfer.
- `xfer_done`  out  1: one-cycle pulse when an end-of-transfer completes.
- `proto_err`  out  1: sticky flag for an illegal handshake sequence; cleared only by reset.

## Operation
- **Input register:** `to_hw_sig` and `to_hw_port` pass through one register stage (`sig_q`, `port_q`). All decode uses the registered values.
- **FSM states:** IDLE, ACK.
- **IDLE:**
  - `sig_q == 01` and FIFO not full: write `port_q`, increment `word_count` (wraps), set `ack_code = 01`, go to ACK.
  - `sig_q == 01` and FIFO full: stay in IDLE, no write; the command is retried each cycle.
  - `sig_q == 10` and FIFO empty: `last_count <= word_count`, `word_count <= 0`, pulse `xfer_done`, `ack_code = 10`, go to ACK.
  - `sig_q == 10` and FIFO not empty: stay in IDLE until the FIFO drains.
  - `sig_q == 11`: flush the FIFO, `word_count <= 0`, no `xfer_done`, `ack_code = 11`, go to ACK. Abort is not gated by full or empty.
- **ACK:**
  - `sig_q == 00`: go to IDLE.
  - `sig_q == ack_code`: hold in ACK.
  - Any other nonzero code: set `proto_err`, hold in ACK, take no action on the new code.
- **Outputs from flops:** `to_sw_sig[0]` = (state == ACK). `to_sw_sig[1]` = FIFO full. Both come directly from registers.
- **FIFO:** circular buffer with read/write pointers wrapping modulo FIFO_DEPTH. `fifo_level` updates as +write − read.
  - A simultaneous write and read is allowed. Write eligibility uses the pre-read level, so a full FIFO does not accept a write in the same cycle as a read.
  - `out_valid = (fifo_level != 0)`. `out_data = mem[rd_ptr]`.
- **Abort vs. read:** a read handshake in the abort cycle completes (that word counts as delivered); all other contents are then discarded. After the flush, level = 0 and pointers = 0.
- **Reset values:** state IDLE. `to_sw_sig = 00`, `out_valid = 0`, `fifo_level = 0`, `word_count = 0`, `last_count = 0`, `xfer_done = 0`, `proto_err = 0`, `sig_q = 00`. `out_data` is don't-care while `out_valid = 0`.
- **Reset mid-transfer:** FIFO contents are lost; software must restart the transfer.

## Timing
- **Command to ack:** command present before edge k → `sig_q` at k → FIFO write and ACK entry at k+1. `to_sw_sig[0]` and `out_valid` are high after edge k+1 (2-cycle latency).
- **Ack release:** `to_hw_sig = 00` before edge m → `to_sw_sig[0]` low after edge m+1.
- **Throughput:** minimum 4 cycles per word, limited by the handshake.
- **`xfer_done`:** high for exactly the cycle following the ACK-entry edge of an end command.
- **Stream side:** zero-latency show-ahead; one word per cycle when `out_ready` is held high.

## Test plan
- **Single word:** `to_hw_port = 16'hA5C3`, `to_hw_sig = 01`, `out_ready = 0` → 2 cycles later ack = 1, `out_valid = 1`, `out_data = A5C3`, `fifo_level = 1`, `word_count = 1`. Then `to_hw_sig = 00` → ack = 0 two cycles later.
- **Full stall (FIFO_DEPTH = 4):** `out_ready = 0`, words 0x0001–0x0005 → busy = 1 after the 4th word; the 5th word is not acked. Pulse `out_ready` one cycle → 5th word acked. Stream order is 1, 2, 3, 4, 5.
- **End with drain:** 3 words, then `to_hw_sig = 10` with `out_ready = 0` → no ack. Set `out_ready = 1` → after the FIFO empties, `xfer_done` pulses once, `last_count = 3`, `word_count = 0`, ack = 1.
- **Abort:** 2 words buffered, `to_hw_sig = 11` → ack = 1, `fifo_level = 0`, `out_valid = 0`, `word_count = 0`, `xfer_done` never pulses.
- **Protocol error:** in ACK after 01, drive `to_hw_sig = 10` without returning to 00 → `proto_err = 1`, ack stays 1, `last_count` unchanged. Then drive 00 → IDLE; `proto_err` stays 1.
- **Reset mid-operation:** in ACK with 2 words buffered, hold `reset_reset_n = 0` for one edge → all outputs at their reset values on the next cycle.
